// File: rtl/multicycle_control.sv
// krv32 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with traps
// on illegal modes and on memory handshake timeouts.
module multicycle_control #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       mode,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             timeout_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_t          st_q;
  state_t          st_d;
  logic [3:0]      mode_q;
  logic [TO_W-1:0] to_q;
  logic            to_hit;
  logic            set_ill;
  logic            set_to;
  logic            bad_mode;

  assign state    = st_q;
  assign to_hit   = (to_q == TO_MAX);
  assign bad_mode = (mode == 4'd9) || (mode > 4'd10);

  always_comb begin
    st_d     = st_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    wb_sel   = 2'd0;
    set_ill  = 1'b0;
    set_to   = 1'b0;
    unique case (st_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we = 1'b1;
          st_d  = S_DECODE;
        end else if (to_hit) begin
          st_d   = S_TRAP;
          set_to = 1'b1;
        end
      end
      S_DECODE: begin
        if (bad_mode) begin
          st_d    = S_TRAP;
          set_ill = 1'b1;
        end else if (mode == 4'd0) begin
          pc_we = 1'b1;
          st_d  = S_FETCH;
        end else begin
          st_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (mode_q == 4'd3 || mode_q == 4'd4) begin
          st_d = S_MEM;
        end else if (mode_q == 4'd5) begin
          pc_we  = 1'b1;
          pc_sel = {1'b0, branch_taken};
          st_d   = S_FETCH;
        end else begin
          st_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (mode_q == 4'd4);
        if (dmem_ack) begin
          if (mode_q == 4'd4) begin
            pc_we = 1'b1;
            st_d  = S_FETCH;
          end else begin
            st_d = S_WB;
          end
        end else if (to_hit) begin
          st_d   = S_TRAP;
          set_to = 1'b1;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        st_d  = S_FETCH;
        unique case (1'b1)
          mode_q == 4'd3:  wb_sel = 2'd1;
          mode_q == 4'd6: begin
            wb_sel = 2'd2;
            pc_sel = 2'd1;
          end
          mode_q == 4'd10: begin
            wb_sel = 2'd2;
            pc_sel = 2'd2;
          end
          mode_q == 4'd7:  wb_sel = 2'd3;
          default:         wb_sel = 2'd0;
        endcase
      end
      S_TRAP: st_d = S_TRAP;
      default: st_d = S_TRAP;
    endcase
    // Strobes stay quiet while reset is being applied.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'd0;
      wb_sel   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= S_FETCH;
      mode_q      <= 4'd0;
      to_q        <= '0;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
      instr_count <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == S_DECODE) mode_q <= mode;
      // Counter restarts whenever a state is (re)entered.
      if (st_d != st_q) begin
        to_q <= '0;
      end else if (st_q == S_FETCH || st_q == S_MEM) begin
        to_q <= to_q + TO_W'(1);
      end
      if (set_ill) illegal <= 1'b1;
      if (set_to) timeout_err <= 1'b1;
      if (pc_we) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, corner sequences and
// randomized instructions against a per-instruction cycle-trace model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mode = 4'd0;
  logic        branch_taken = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
  logic [1:0]  pc_sel, wb_sel;
  logic        illegal, timeout_err;
  logic [2:0]  state;
  logic [31:0] instr_count;

  multicycle_control #(.CNT_W(32), .TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .wb_sel(wb_sel),
    .illegal(illegal), .timeout_err(timeout_err), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic ireq, irwe, dreq, dwe, rfwe, pcwe;
    logic [1:0] pcs, wbs;
    logic ill, toe;
  } exp_t;

  typedef struct {
    exp_t e;
    logic ia;
    logic da;
  } row_t;

  typedef struct {
    logic [3:0] m;
    int fd;
    int md;
    logic bt;
    int cyc;
    logic [1:0] pcs;
    logic [1:0] wbs;
    logic rf;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_cnt = 0;
  logic        b_ill, b_toe;
  row_t        tr[$];
  vec_t        tbl[13];
  logic [3:0]  legal[10];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic row_t mk(input logic [2:0] s);
    row_t r;
    r.e = '0;
    r.e.st = s;
    r.e.ill = b_ill;
    r.e.toe = b_toe;
    r.ia = 1'b0;
    r.da = 1'b0;
    return r;
  endfunction

  task automatic add_trap();
    for (int i = 0; i < 20; i++) tr.push_back(mk(3'd5));
  endtask

  // Expected cycle-by-cycle trace of one instruction from the phase rules.
  task automatic build(input vec_t v);
    row_t r;
    int   n;
    tr.delete();
    b_ill = 1'b0;
    b_toe = 1'b0;
    n = (v.fd > 15) ? 16 : v.fd + 1;
    for (int i = 0; i < n; i++) begin
      r = mk(3'd0);
      r.e.ireq = 1'b1;
      r.ia = (i == v.fd);
      r.e.irwe = r.ia;
      tr.push_back(r);
    end
    if (v.fd > 15) begin
      b_toe = 1'b1;
      add_trap();
      return;
    end
    r = mk(3'd1);
    if (v.m == 4'd9 || v.m > 4'd10) begin
      tr.push_back(r);
      b_ill = 1'b1;
      add_trap();
      return;
    end
    if (v.m == 4'd0) begin
      r.e.pcwe = 1'b1;
      tr.push_back(r);
      return;
    end
    tr.push_back(r);
    r = mk(3'd2);
    if (v.m == 4'd5) begin
      r.e.pcwe = 1'b1;
      r.e.pcs = {1'b0, v.bt};
      tr.push_back(r);
      return;
    end
    tr.push_back(r);
    if (v.m == 4'd3 || v.m == 4'd4) begin
      n = (v.md > 15) ? 16 : v.md + 1;
      for (int i = 0; i < n; i++) begin
        r = mk(3'd3);
        r.e.dreq = 1'b1;
        r.e.dwe = (v.m == 4'd4);
        r.da = (i == v.md);
        r.e.pcwe = (v.m == 4'd4) && r.da;
        tr.push_back(r);
      end
      if (v.md > 15) begin
        b_toe = 1'b1;
        add_trap();
        return;
      end
      if (v.m == 4'd4) return;
    end
    r = mk(3'd4);
    r.e.rfwe = 1'b1;
    r.e.pcwe = 1'b1;
    case (v.m)
      4'd3:  r.e.wbs = 2'd1;
      4'd6:  begin r.e.wbs = 2'd2; r.e.pcs = 2'd1; end
      4'd10: begin r.e.wbs = 2'd2; r.e.pcs = 2'd2; end
      4'd7:  r.e.wbs = 2'd3;
      default: ;
    endcase
    tr.push_back(r);
  endtask

  task automatic run(input vec_t v, input int max_rows, output int cyc,
                     output logic [1:0] pcs, output logic [1:0] wbs,
                     output logic rf);
    row_t r;
    int   n;
    build(v);
    n = (max_rows > 0 && max_rows < tr.size()) ? max_rows : tr.size();
    pcs = 2'd0;
    wbs = 2'd0;
    rf = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = tr[i];
      imem_ack = (r.e.st == 3'd0) ? r.ia : 1'($urandom);
      dmem_ack = (r.e.st == 3'd3) ? r.da : 1'($urandom);
      mode = (r.e.st == 3'd1) ? v.m : 4'($urandom);
      branch_taken = (r.e.st == 3'd2) ? v.bt : 1'($urandom);
      #1;
      check("cyc", {state, imem_req, ir_we, dmem_req, dmem_we, rf_we,
                    pc_we, pc_sel, wb_sel, illegal, timeout_err}, r.e);
      check("cnt", instr_count, m_cnt);
      if (pc_we) begin
        pcs = pc_sel;
        wbs = wb_sel;
        rf = rf_we;
      end
      if (r.e.pcwe) m_cnt++;
      @(negedge clk);
    end
    cyc = n;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
    #1;
    check("rst_strobe", {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we},
          6'd0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    #1;
    check("rst_state", {state, illegal, timeout_err}, 5'd0);
    check("rst_cnt", instr_count, 32'd0);
    check("rst_req", {imem_req, dmem_req}, 2'b10);
  endtask

  function automatic vec_t mv(input logic [3:0] m, input int fd,
                              input int md, input logic bt);
    vec_t v;
    v = '{m: m, fd: fd, md: md, bt: bt, cyc: 0, pcs: 2'd0, wbs: 2'd0,
          rf: 1'b0};
    return v;
  endfunction

  initial begin
    int         c;
    logic [1:0] p, w;
    logic       f;
    vec_t       v;

    tbl[0]  = '{4'd1,  0,  0, 1'b0,  4, 2'd0, 2'd0, 1'b1};
    tbl[1]  = '{4'd3,  0,  3, 1'b0,  8, 2'd0, 2'd1, 1'b1};
    tbl[2]  = '{4'd5,  0,  0, 1'b1,  3, 2'd1, 2'd0, 1'b0};
    tbl[3]  = '{4'd5,  0,  0, 1'b0,  3, 2'd0, 2'd0, 1'b0};
    tbl[4]  = '{4'd10, 0,  0, 1'b0,  4, 2'd2, 2'd2, 1'b1};
    tbl[5]  = '{4'd4,  0,  0, 1'b0,  4, 2'd0, 2'd0, 1'b0};
    tbl[6]  = '{4'd0,  0,  0, 1'b0,  2, 2'd0, 2'd0, 1'b0};
    tbl[7]  = '{4'd2,  2,  0, 1'b0,  6, 2'd0, 2'd0, 1'b1};
    tbl[8]  = '{4'd6,  0,  0, 1'b0,  4, 2'd1, 2'd2, 1'b1};
    tbl[9]  = '{4'd7,  0,  0, 1'b0,  4, 2'd0, 2'd3, 1'b1};
    tbl[10] = '{4'd8,  1,  0, 1'b0,  5, 2'd0, 2'd0, 1'b1};
    tbl[11] = '{4'd3, 15,  0, 1'b0, 20, 2'd0, 2'd1, 1'b1};
    tbl[12] = '{4'd4,  0, 15, 1'b0, 19, 2'd0, 2'd0, 1'b0};
    legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      run(tbl[i], 0, c, p, w, f);
      check($sformatf("lat%0d", i), 64'(c), 64'(tbl[i].cyc));
      check($sformatf("pcs%0d", i), 64'(p), 64'(tbl[i].pcs));
      check($sformatf("wbs%0d", i), 64'(w), 64'(tbl[i].wbs));
      check($sformatf("rf%0d", i), 64'(f), 64'(tbl[i].rf));
    end
    check("count13", instr_count, 32'd13);

    run(mv(4'd9, 0, 0, 1'b0), 0, c, p, w, f);
    do_reset();
    run(mv(4'd13, 1, 0, 1'b0), 0, c, p, w, f);
    do_reset();
    run(mv(4'd1, 16, 0, 1'b0), 0, c, p, w, f);
    do_reset();
    run(mv(4'd3, 0, 16, 1'b0), 0, c, p, w, f);
    do_reset();
    run(mv(4'd4, 0, 5, 1'b0), 4, c, p, w, f);
    do_reset();

    for (int k = 0; k < 120; k++) begin
      v = mv(legal[$urandom_range(0, 9)], $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 19) == 0) v.m = 4'($urandom_range(11, 15));
      if ($urandom_range(0, 29) == 0) v.m = 4'd9;
      if ($urandom_range(0, 29) == 0) v.fd = 16;
      if ($urandom_range(0, 29) == 0) v.md = 16;
      run(v, 0, c, p, w, f);
      if (b_ill || b_toe) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
